// File: rtl/ata_wb_pkg.sv
// Shared types and constants for the ATA Wishbone master: FSM states, response codes
// and the controller register map expressed as A6..A2 word addresses.
package ata_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        GAP  = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] RSP_OK  = 2'b00;
    localparam logic [1:0] RSP_ERR = 2'b01;
    localparam logic [1:0] RSP_RTY = 2'b10;
    localparam logic [1:0] RSP_TMO = 2'b11;

    // Controller register word addresses (byte offset >> 2); A6=1 selects the device
    localparam logic [4:0] ADR_CTRL     = 5'h00;
    localparam logic [4:0] ADR_STAT     = 5'h01;
    localparam logic [4:0] ADR_PCTR     = 5'h02;
    localparam logic [4:0] ADR_PFTR0    = 5'h03;
    localparam logic [4:0] ADR_PFTR1    = 5'h04;
    localparam logic [4:0] ADR_DTR0     = 5'h05;
    localparam logic [4:0] ADR_DTR1     = 5'h06;
    localparam logic [4:0] ADR_TXB_RXB  = 5'h0F;
    localparam logic [4:0] ADR_DEV_BASE = 5'h10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ata_wb_timer.sv
// Loadable saturating down-counter; reused for the bus-phase timeout and the retry gap.
module ata_wb_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/ata_wb_master.sv
// Wishbone classic master for the ATA host controller slave port: turns a 16-bit
// command/response handshake into single register cycles with retry and timeout.
module ata_wb_master
    import ata_wb_pkg::*;
#(
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 3,
    parameter int RETRY_GAP = 4
) (
    input  logic        wb_clk_i,
    input  logic        arst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [4:0]  cmd_adr_i,
    input  logic [15:0] cmd_dat_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [15:0] rsp_dat_o,
    output logic [1:0]  rsp_code_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i
);

    localparam int TW = max_int($clog2(TIMEOUT + 1), 8);
    localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'(RETRY_GAP - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [4:0]    adr_q, adr_d;
    logic [15:0]   dat_q, dat_d;
    logic [3:0]    retry_q, retry_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          cyc_q, cyc_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [15:0]   rsp_dat_q, rsp_dat_d;
    logic [1:0]    rsp_code_q, rsp_code_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_en;
    logic          tmr_zero;

    // Upper half of the slave data bus carries nothing for 16-bit registers
    logic unused_dat_hi;
    assign unused_dat_hi = ^wb_dat_i[31:16];

    ata_wb_timer #(.W(TW)) u_timer (
        .clk      (wb_clk_i),
        .rst_n    (arst_i),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        retry_d    = retry_q;
        rsp_dat_d  = rsp_dat_q;
        rsp_code_d = rsp_code_q;
        tmr_load   = 1'b0;
        tmr_val    = TO_LOAD;
        tmr_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    we_d     = cmd_we_i;
                    adr_d    = cmd_adr_i;
                    dat_d    = cmd_dat_i;
                    retry_d  = 4'd0;
                    tmr_load = 1'b1;
                    tmr_val  = TO_LOAD;
                    state_d  = BUS;
                end
            end
            BUS: begin
                if (wb_err_i) begin
                    rsp_code_d = RSP_ERR;
                    rsp_dat_d  = 16'h0000;
                    state_d    = RESP;
                end else if (wb_ack_i) begin
                    rsp_code_d = RSP_OK;
                    rsp_dat_d  = we_q ? 16'h0000 : wb_dat_i[15:0];
                    state_d    = RESP;
                end else if (wb_rty_i) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d  = retry_q + 4'd1;
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LOAD;
                        state_d  = GAP;
                    end else begin
                        rsp_code_d = RSP_RTY;
                        rsp_dat_d  = 16'h0000;
                        state_d    = RESP;
                    end
                end else if (tmr_zero) begin
                    // Timer was loaded with TIMEOUT-1, so this is the TIMEOUT-th stb cycle
                    rsp_code_d = RSP_TMO;
                    rsp_dat_d  = 16'h0000;
                    state_d    = RESP;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            GAP: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = TO_LOAD;
                    state_d  = BUS;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so no bus input reaches a port combinationally
        cmd_ready_d = (state_d == IDLE);
        cyc_d       = (state_d == BUS);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            adr_q       <= 5'd0;
            dat_q       <= 16'h0000;
            retry_q     <= 4'd0;
            cmd_ready_q <= 1'b0;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= 16'h0000;
            rsp_code_q  <= RSP_OK;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            retry_q     <= retry_d;
            cmd_ready_q <= cmd_ready_d;
            cyc_q       <= cyc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_code_q  <= rsp_code_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_code_o  = rsp_code_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_we_o     = we_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = {16'h0000, dat_q};
    assign wb_sel_o    = 4'b1111;

endmodule

// File: tb/tb_ata_wb_master.sv
// Directed bench for ata_wb_master: bench-driven slave responses, hand-computed expectations.
module tb_ata_wb_master;

    logic        clk = 1'b0;
    logic        arst_i;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [4:0]  cmd_adr_i;
    logic [15:0] cmd_dat_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [15:0] rsp_dat_o;
    logic [1:0]  rsp_code_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [4:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i, wb_err_i, wb_rty_i;

    int n_checks = 0;
    int n_pass   = 0;

    ata_wb_master #(.TIMEOUT(255), .MAX_RETRY(3), .RETRY_GAP(4)) dut (
        .wb_clk_i    (clk),
        .arst_i      (arst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_adr_i   (cmd_adr_i),
        .cmd_dat_i   (cmd_dat_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_code_o  (rsp_code_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_sel_o    (wb_sel_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i),
        .wb_err_i    (wb_err_i),
        .wb_rty_i    (wb_rty_i)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Offer one command; returns at the negedge of the first BUS cycle
    task automatic issue(input logic we, input logic [4:0] adr, input logic [15:0] dat);
        int w;
        @(negedge clk);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        w = 0;
        while (!cmd_ready_o && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        cmd_valid_i = 1'b0;
        check_eq("stb_latency", {31'd0, wb_stb_o}, 32'd1);
    endtask

    // Slave side: terminate on the ack_at-th stb cycle (0 = never); returns stb-high length
    task automatic bus_resp(input int ack_at, input logic with_err, input logic with_ack,
                            input logic [31:0] rdata, output int hi);
        hi = 0;
        while (wb_stb_o && hi < 400) begin
            if (ack_at != 0 && hi == ack_at - 1) begin
                wb_ack_i = with_ack;
                wb_err_i = with_err;
                wb_dat_i = rdata;
            end
            hi++;
            @(negedge clk);
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wb_dat_i = 32'h0;
        end
    endtask

    task automatic rty_once(output int gap);
        wb_rty_i = 1'b1;
        @(negedge clk);
        wb_rty_i = 1'b0;
        gap = 0;
        while (!wb_stb_o && gap < 50) begin
            gap++;
            @(negedge clk);
        end
    endtask

    task automatic take_rsp(input string tag, output logic [15:0] dat, output logic [1:0] code);
        int w;
        w = 0;
        while (!rsp_valid_o && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_eq({tag, "_rsp_valid"}, {31'd0, rsp_valid_o}, 32'd1);
        dat  = rsp_dat_o;
        code = rsp_code_o;
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        check_eq({tag, "_cmd_ready_after"}, {31'd0, cmd_ready_o}, 32'd1);
        $display("txn %s: code=%0d dat=%h", tag, code, dat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, gap, bursts, extra;
        logic [15:0] d;
        logic [1:0]  c;
        logic        stable;

        arst_i = 1'b0;
        cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = 5'd0; cmd_dat_i = 16'h0;
        rsp_ready_i = 1'b0;
        wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;

        #1;
        check_eq("rst_outputs", {cmd_ready_o, rsp_valid_o, wb_cyc_o, wb_stb_o, wb_we_o,
                                 wb_adr_o, rsp_code_o}, 32'd0);
        check_eq("rst_sel", {28'd0, wb_sel_o}, 32'hF);
        check_eq("rst_data", {rsp_dat_o, wb_dat_o[15:0]}, 32'd0);
        repeat (2) @(negedge clk);
        arst_i = 1'b1;
        @(negedge clk);
        check_eq("idle_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);

        // Write CTRL, ack on 2nd stb cycle
        issue(1'b1, 5'h00, 16'h0082);
        check_eq("wr_bus", {wb_cyc_o, wb_we_o, wb_sel_o, 21'd0, wb_adr_o}, {1'b1, 1'b1, 4'hF, 26'd0});
        check_eq("wr_wb_dat", wb_dat_o, 32'h0000_0082);
        bus_resp(2, 1'b0, 1'b1, 32'hFFFF_FFFF, hi);
        check_eq("wr_stb_len", hi, 2);
        take_rsp("write", d, c);
        check_eq("wr_rsp", {14'd0, c, d}, 32'h0);

        // Read STAT, then stall the response 10 cycles
        issue(1'b0, 5'h01, 16'h0000);
        check_eq("rd_cmd_ready_bus", {31'd0, cmd_ready_o}, 32'd0);
        check_eq("rd_bus", {wb_we_o, 26'd0, wb_adr_o}, 32'd1);
        bus_resp(1, 1'b0, 1'b1, 32'hDEAD_1234, hi);
        check_eq("rd_stb_len", hi, 1);
        stable = 1'b1;
        repeat (10) begin
            if (!(rsp_valid_o && rsp_dat_o == 16'h1234 && rsp_code_o == 2'b00 &&
                  !cmd_ready_o && !wb_cyc_o)) stable = 1'b0;
            @(negedge clk);
        end
        check_eq("rd_stall_stable", {31'd0, stable}, 32'd1);
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        check_eq("rd_release", {30'd0, cmd_ready_o, rsp_valid_o}, 32'b10);
        $display("txn read: code=0 dat=1234 after 10-cycle stall");

        // Three rty then ack
        issue(1'b0, 5'h02, 16'h0000);
        bursts = 0;
        for (int k = 0; k < 4; k++) begin
            if (wb_stb_o) bursts++;
            if (k < 3) begin
                rty_once(gap);
                check_eq("rty3_gap", gap, 4);
            end else begin
                bus_resp(1, 1'b0, 1'b1, 32'h0000_5A5A, hi);
            end
        end
        check_eq("rty3_bursts", bursts, 4);
        take_rsp("retry3", d, c);
        check_eq("rty3_rsp", {14'd0, c, d}, {14'd0, 2'b00, 16'h5A5A});

        // Four rty -> retries exhausted, no fifth burst
        issue(1'b0, 5'h03, 16'h0000);
        bursts = 0;
        for (int k = 0; k < 4; k++) begin
            if (wb_stb_o) bursts++;
            rty_once(gap);
            if (k < 3) check_eq("rty4_gap", gap, 4);
        end
        extra = 0;
        repeat (10) begin
            if (wb_stb_o) extra++;
            @(negedge clk);
        end
        check_eq("rty4_bursts", bursts, 4);
        check_eq("rty4_no_fifth", extra, 0);
        take_rsp("retry4", d, c);
        check_eq("rty4_code", {30'd0, c}, 32'd2);

        // Timeout
        issue(1'b0, 5'h04, 16'h0000);
        bus_resp(0, 1'b0, 1'b0, 32'h0, hi);
        check_eq("tmo_stb_len", hi, 255);
        check_eq("tmo_cyc", {31'd0, wb_cyc_o}, 32'd0);
        take_rsp("timeout", d, c);
        check_eq("tmo_code", {30'd0, c}, 32'd3);

        // err and ack together: err wins
        issue(1'b0, 5'h05, 16'h0000);
        bus_resp(1, 1'b1, 1'b1, 32'h0000_BEEF, hi);
        take_rsp("err_ack", d, c);
        check_eq("errack_rsp", {14'd0, c, d}, {14'd0, 2'b01, 16'h0000});

        // Stray terminations while idle
        @(negedge clk);
        wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_rty_i = 1'b1;
        repeat (2) @(negedge clk);
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
        check_eq("stray_ignored", {29'd0, cmd_ready_o, rsp_valid_o, wb_cyc_o}, 32'b100);

        // Async reset during BUS cycle 3
        issue(1'b0, 5'h06, 16'h0000);
        repeat (2) @(negedge clk);
        #2 arst_i = 1'b0;
        #1;
        check_eq("arst_drop", {29'd0, wb_cyc_o, wb_stb_o, rsp_valid_o}, 32'd0);
        @(negedge clk);
        arst_i = 1'b1;
        check_eq("arst_ready_low", {31'd0, cmd_ready_o}, 32'd0);
        @(negedge clk);
        check_eq("arst_ready_high", {30'd0, cmd_ready_o, wb_cyc_o}, 32'b10);
        issue(1'b0, 5'h0F, 16'h0000);
        bus_resp(1, 1'b0, 1'b1, 32'h1111_C0DE, hi);
        take_rsp("post_reset", d, c);
        check_eq("post_reset_rsp", {14'd0, c, d}, {14'd0, 2'b00, 16'hC0DE});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
